// File: rtl/spi_sram_pkg.sv
// Shared command codes and FSM state encoding for the SPI SRAM slave.
package spi_sram_pkg;

  localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
  localparam logic [7:0] CMD_READ_DATA  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_READ   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the old value of
      // its predecessor; blocking here would collapse the chain into one flop.
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_sram_slave.sv
// SPI (mode 3, sck idle high) slave in front of a small byte array.
// Commands: 0x02 write, 0x03 read, each followed by a 3-byte address and a
// stream of data bytes with auto-incrementing, wrapping pointer.
module spi_sram_slave
  import spi_sram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy
);

  localparam int MEM_BYTES  = 1 << MEM_ADDR_BITS;
  localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;

  logic w_sck_rise, w_sck_fall, w_unused_sck_level;
  logic w_ss_rise, w_ss_fall, w_unused_ss_level;
  logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_sck (
    .clock(clock), .reset(reset), .i_async(spi_sck),
    .o_sync(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .i_async(spi_ss),
    .o_sync(w_unused_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .i_async(spi_mosi),
    .o_sync(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  state_t                   r_state;
  logic [2:0]               r_bit_cnt;
  logic [1:0]               r_byte_cnt;
  logic [7:0]               r_shift;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic [MEM_ADDR_BITS-1:0] r_ptr;
  logic                     r_is_read;
  logic [7:0]               r_out;
  logic                     r_miso;
  logic                     r_busy;
  logic                     r_wr_pending;
  logic [7:0]               r_wr_data;
  logic [7:0]               r_mem [MEM_BYTES];

  // Byte being completed by the current rising edge, and the address with
  // the current bit appended; upper address bits fall off the top (aliasing).
  logic [7:0]               w_byte_in;
  logic [MEM_ADDR_BITS-1:0] w_addr_next;
  assign w_byte_in   = {r_shift[6:0], w_mosi};
  assign w_addr_next = {r_addr[MEM_ADDR_BITS-2:0], w_mosi};

  // Memory write port: commits a completed byte one cycle after its last bit.
  always_ff @(posedge clock) begin
    // NOTE: no reset on the array; contents must survive reset and a reset
    // branch would also block RAM inference.
    if (r_wr_pending) r_mem[r_ptr] <= r_wr_data;
  end

  // Transaction FSM with registered miso/busy; ss rising overrides sck edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_ptr        <= '0;
      r_is_read    <= 1'b0;
      r_out        <= '0;
      r_miso       <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_pending <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      if (r_wr_pending) begin
        r_wr_pending <= 1'b0;
        r_ptr        <= r_ptr + 1'b1;
      end

      if (w_ss_rise) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_ss_fall) begin
              r_state   <= ST_CMD;
              r_busy    <= 1'b1;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= '0;
                r_is_read  <= (w_byte_in == CMD_READ_DATA);
                if (w_byte_in == CMD_READ_DATA || w_byte_in == CMD_WRITE_DATA)
                  r_state <= ST_ADDR;
                else
                  r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_addr    <= w_addr_next;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                if (r_byte_cnt == 2'(ADDR_BYTES - 1)) begin
                  if (r_is_read) begin
                    r_state <= ST_READ;
                    r_out   <= r_mem[w_addr_next];
                    r_ptr   <= w_addr_next + 1'b1;
                  end else begin
                    r_state <= ST_WRITE;
                    r_ptr   <= w_addr_next;
                  end
                end
              end
            end
          end
          ST_WRITE: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_wr_pending <= 1'b1;
                r_wr_data    <= w_byte_in;
              end
            end
          end
          ST_READ: begin
            if (w_sck_fall) begin
              r_miso    <= r_out[7];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_out <= r_mem[r_ptr];
                r_ptr <= r_ptr + 1'b1;
              end else begin
                r_out <= {r_out[6:0], 1'b0};
              end
            end
          end
          ST_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso = r_miso;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Self-checking bench for spi_sram_slave: an SPI master drives directed and
// random transactions; a byte-array model predicts every bit returned on miso.
module tb_spi_sram_slave;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic spi_sck  = 1'b1;
  logic spi_ss   = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic busy;

  spi_sram_slave #(.ADDRESS_WIDTH(24), .MEM_ADDR_BITS(10)) dut (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int half_clks = 4;

  // Reference model: the byte array as the master should see it.
  logic [7:0] model_mem [1024];
  // 0: no check, 1: miso must be 0, 2: miso must match exp_q
  int         chk_mode = 0;
  logic       exp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];
  int         start_q[$];
  int         len_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int wrap_idx(input logic [23:0] a, input int i);
    return (int'(a) + i) % 1024;
  endfunction

  // Compare process: master samples miso on each sck rising edge.
  always @(posedge spi_sck) begin
    if (chk_mode == 1) begin
      check("miso_zero", 32'(spi_miso), 32'd0);
    end else if (chk_mode == 2) begin
      if (exp_q.size() != 0) begin
        logic b;
        b = exp_q.pop_front();
        check("miso_bit", 32'(spi_miso), 32'(b));
      end else begin
        n_checks++;
        n_errors++;
        $display("FAIL miso_unexpected_bit got %b expected none", spi_miso);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[i];
      wait_clks(half_clks);
      spi_sck  = 1'b1;
      rx[i]    = spi_miso;
      wait_clks(half_clks);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_begin();
    spi_ss = 1'b0;
    wait_clks(4);
    check("busy_in_txn", 32'(busy), 32'd1);
  endtask

  task automatic spi_end();
    int c;
    spi_ss = 1'b1;
    c = 0;
    while (busy === 1'b1 && c < 8) begin
      wait_clks(1);
      c++;
    end
    n_checks++;
    if (!(c >= 2 && c <= 3)) begin
      n_errors++;
      $display("FAIL busy_fall_latency got %0d cycles expected 2..3", c);
    end
    spi_mosi = 1'b0;
    wait_clks(2);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    spi_byte(cmd);
    spi_byte(addr[23:16]);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
  endtask

  // Writes wr_q starting at addr and updates the model.
  task automatic write_txn(input logic [23:0] addr);
    chk_mode = 1;
    spi_begin();
    send_header(8'h02, addr);
    foreach (wr_q[i]) spi_byte(wr_q[i]);
    spi_end();
    chk_mode = 0;
    foreach (wr_q[i]) model_mem[wrap_idx(addr, i)] = wr_q[i];
  endtask

  // Reads n bytes into rd_q; every bit is also checked against the model.
  task automatic read_txn(input logic [23:0] addr, input int n);
    logic [7:0] rx;
    chk_mode = 1;
    spi_begin();
    send_header(8'h03, addr);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) exp_q.push_back(model_mem[wrap_idx(addr, i)][b]);
    rd_q.delete();
    chk_mode = 2;
    for (int i = 0; i < n; i++) begin
      spi_bits(8'($urandom), 8, rx);
      rd_q.push_back(rx);
    end
    chk_mode = 0;
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    spi_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    // Reset state
    wait_clks(3);
    check("reset_miso", 32'(spi_miso), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clks(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic write then read back
    half_clks = 4;
    wr_q = '{8'hA5, 8'h3C};
    write_txn(24'h000010);
    read_txn(24'h000010, 2);
    check("read_0x10", 32'(rd_q[0]), 32'hA5);
    check("read_0x11", 32'(rd_q[1]), 32'h3C);

    // Abort mid-byte: completed byte kept, partial byte dropped
    wr_q = '{8'h55, 8'h66};
    write_txn(24'h000020);
    chk_mode = 1;
    spi_begin();
    send_header(8'h02, 24'h000020);
    spi_byte(8'hFF);
    spi_bits(8'h00, 5, rx);
    spi_end();
    chk_mode = 0;
    check("abort_idle", 32'(busy), 32'd0);
    model_mem[32'h20] = 8'hFF;
    read_txn(24'h000020, 2);
    check("abort_0x20", 32'(rd_q[0]), 32'hFF);
    check("abort_0x21", 32'(rd_q[1]), 32'h66);

    // Pointer wrap at the top of the array
    wr_q = '{8'h11, 8'h22};
    write_txn(24'h0003FF);
    read_txn(24'h0003FF, 2);
    check("wrap_0x3ff", 32'(rd_q[0]), 32'h11);
    check("wrap_0x000", 32'(rd_q[1]), 32'h22);
    read_txn(24'h000000, 1);
    check("direct_0x000", 32'(rd_q[0]), 32'h22);

    // Unknown command: miso held low, memory untouched
    chk_mode = 1;
    spi_begin();
    spi_byte(8'h9F);
    for (int i = 0; i < 4; i++) spi_byte(8'($urandom));
    check("ignore_busy", 32'(busy), 32'd1);
    spi_end();
    chk_mode = 0;
    read_txn(24'h000010, 2);
    check("after_ignore_0x10", 32'(rd_q[0]), 32'hA5);
    check("after_ignore_0x11", 32'(rd_q[1]), 32'h3C);

    // Reset during READ
    chk_mode = 1;
    spi_begin();
    send_header(8'h03, 24'h000010);
    chk_mode = 0;
    spi_bits(8'h00, 3, rx);
    reset  = 1'b1;
    spi_ss = 1'b1;
    spi_sck = 1'b1;
    #1;
    check("midreset_miso", 32'(spi_miso), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3);
    read_txn(24'h000010, 2);
    check("post_reset_0x10", 32'(rd_q[0]), 32'hA5);
    check("post_reset_0x11", 32'(rd_q[1]), 32'h3C);

    // Random traffic, upper address bits random to exercise aliasing
    for (int t = 0; t < 24; t++) begin
      half_clks = $urandom_range(4, 6);
      if (start_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        int lo, n;
        logic [23:0] a;
        lo = $urandom_range(0, 1023);
        n  = $urandom_range(1, 4);
        a  = {14'($urandom), 10'(lo)};
        wr_q.delete();
        for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
        write_txn(a);
        start_q.push_back(lo);
        len_q.push_back(n);
      end else begin
        int k;
        k = $urandom_range(0, start_q.size() - 1);
        read_txn({14'($urandom), 10'(start_q[k])}, len_q[k]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
